// File: rtl/snax_csr_responder.sv
// snax_csr_responder: CSR request/response responder with a RW config bank, RO status inputs and a launch handshake.
// Optional stall counter at address NumRwCsr+NumRoCsr+1 when SNAX_CSR_PERF_CNT_EN is defined.
module snax_csr_responder #(
  parameter int NumRwCsr = 8,
  parameter int NumRoCsr = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              csr_req_bits_data_i,
  input  logic [31:0]              csr_req_bits_addr_i,
  input  logic                     csr_req_bits_write_i,
  input  logic                     csr_req_valid_i,
  output logic                     csr_req_ready_o,
  output logic [31:0]              csr_rsp_bits_data_o,
  output logic                     csr_rsp_valid_o,
  input  logic                     csr_rsp_ready_i,
  output logic [32*NumRwCsr-1:0]   csr_reg_set_o,
  output logic                     csr_reg_set_valid_o,
  input  logic                     csr_reg_set_ready_i,
  input  logic [32*NumRoCsr-1:0]   csr_reg_ro_set_i
);

  localparam logic [31:0] LaAddr     = 32'(NumRwCsr + NumRoCsr);
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_PENDING = 1'b1;

  logic [0:0]            launch_state;
  logic [32*NumRwCsr-1:0] cfg_q;
  logic                  rsp_vld_p1;
  logic [31:0]           rsp_data_p1;
  logic [31:0]           rd_data_p0;
  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  launch_fire;

  assign csr_reg_set_valid_o = (launch_state == ST_PENDING);
  assign csr_reg_set_o       = cfg_q;
  assign csr_rsp_valid_o     = rsp_vld_p1;
  assign csr_rsp_bits_data_o = rsp_data_p1;

  // Writes stall while a launch is pending so the config seen by the accelerator stays frozen.
  assign csr_req_ready_o = (!rsp_vld_p1 || csr_rsp_ready_i)
                           && !(csr_req_bits_write_i && csr_reg_set_valid_o);
  assign req_fire    = csr_req_valid_i && csr_req_ready_o;
  assign wr_fire     = req_fire && csr_req_bits_write_i;
  assign rd_fire     = req_fire && !csr_req_bits_write_i;
  assign launch_fire = wr_fire && (csr_req_bits_addr_i == LaAddr) && csr_req_bits_data_i[0];

`ifdef SNAX_CSR_PERF_CNT_EN
  localparam logic [31:0] PaAddr = 32'(NumRwCsr + NumRoCsr + 1);
  logic [31:0] perf_cnt;

  // Counts cycles the accelerator holds off a pending launch; saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt <= '0;
    end else if (launch_fire) begin
      perf_cnt <= '0;
    end else if (csr_reg_set_valid_o && !csr_reg_set_ready_i && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data_p0 = '0;
    for (int k = 0; k < NumRwCsr; k++) begin
      if (csr_req_bits_addr_i == 32'(k)) rd_data_p0 = cfg_q[32*k +: 32];
    end
    for (int k = 0; k < NumRoCsr; k++) begin
      if (csr_req_bits_addr_i == 32'(NumRwCsr + k)) rd_data_p0 = csr_reg_ro_set_i[32*k +: 32];
    end
    if (csr_req_bits_addr_i == LaAddr) rd_data_p0 = {31'b0, csr_reg_set_valid_o};
`ifdef SNAX_CSR_PERF_CNT_EN
    if (csr_req_bits_addr_i == PaAddr) rd_data_p0 = perf_cnt;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < NumRwCsr; k++) begin
        if (csr_req_bits_addr_i == 32'(k)) cfg_q[32*k +: 32] <= csr_req_bits_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      launch_state <= ST_IDLE;
    end else begin
      case (launch_state)
        ST_IDLE:    if (launch_fire) launch_state <= ST_PENDING;
        ST_PENDING: if (csr_reg_set_ready_i) launch_state <= ST_IDLE;
        default:    launch_state <= ST_IDLE;
      endcase
    end
  end

  // p0 -> p1: single-entry response register, reloads when draining and accepting together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else if (rd_fire) begin
      rsp_vld_p1  <= 1'b1;
      rsp_data_p1 <= rd_data_p0;
    end else if (csr_rsp_ready_i) begin
      rsp_vld_p1  <= 1'b0;
    end
  end

endmodule
